// File: rtl/mdu_issue_ctrl.sv
// Multiply/divide issue controller: picks one requesting port, runs a MULT/DIV style
// operation on its latched operands and reports completion with the owning port index.
module mdu_issue_ctrl #(
  parameter int NPORT   = 2,
  parameter int W       = 32,
  parameter int MUL_LAT = 3,
  localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NPORT-1:0]     valid,
  input  logic [NPORT*4-1:0]   op,
  input  logic [NPORT*W-1:0]   a,
  input  logic [NPORT*W-1:0]   b,
  output logic [NPORT-1:0]     ready,
  input  logic                 flush,
  output logic                 done,
  output logic [PW-1:0]        done_port,
  output logic [W-1:0]         result,
  output logic [W-1:0]         hi,
  output logic [W-1:0]         lo,
  output logic                 busy
);

  // Handshake: port i transfers on a rising edge where valid[i] && ready[i]; ready is
  // one-hot on the lowest valid index while idle/done and not flushing, else all-zero.

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;

  localparam int  CMAX    = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int  CW      = $clog2(CMAX + 1);
  localparam bit  MUL_NOW = (MUL_LAT == 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   port_q, port_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d, busy_q, busy_d;

  // Arbitration
  logic [PW-1:0]   win_idx;
  logic [3:0]      op_w;
  logic [W-1:0]    a_w, b_w;
  logic            can_accept, accept;

  always_comb begin
    win_idx = '0;
    op_w    = '0;
    a_w     = '0;
    b_w     = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (valid[i]) begin
        win_idx = PW'(i);
        op_w    = op[4*i +: 4];
        a_w     = a[W*i +: W];
        b_w     = b[W*i +: W];
      end
    end
  end

  assign can_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && !flush;
  assign ready      = can_accept ? (valid & (~valid + NPORT'(1))) : '0;
  assign accept     = |ready;

  // Single multiplier; with a one-cycle latency it works straight off the winning port.
  logic [W-1:0]    mul_a, mul_b;
  logic [3:0]      mul_op;
  logic            mul_sgn;
  logic [2*W-1:0]  ext_a, ext_b, product;

  always_comb begin
    mul_a   = MUL_NOW ? a_w  : a_q;
    mul_b   = MUL_NOW ? b_w  : b_q;
    mul_op  = MUL_NOW ? op_w : op_q;
    mul_sgn = (mul_op != OP_MULTU);
    ext_a   = {{W{mul_sgn & mul_a[W-1]}}, mul_a};
    ext_b   = {{W{mul_sgn & mul_b[W-1]}}, mul_b};
    product = ext_a * ext_b;
  end

  // Restoring radix-2 step on magnitudes; signs are reapplied at commit.
  logic [W:0]      trial, sub;
  logic            qbit;
  logic [W-1:0]    rem_n, quo_n, q_fix, r_fix, lo_div, hi_div;

  always_comb begin
    trial  = {rem_q, quo_q[W-1]};
    sub    = trial - {1'b0, dvs_q};
    qbit   = !sub[W];
    rem_n  = qbit ? sub[W-1:0] : trial[W-1:0];
    quo_n  = {quo_q[W-2:0], qbit};
    q_fix  = q_neg_q ? (~quo_n + 1'b1) : quo_n;
    r_fix  = r_neg_q ? (~rem_n + 1'b1) : rem_n;
    lo_div = dz_q ? '1  : q_fix;
    hi_div = dz_q ? a_q : r_fix;
  end

  logic na_w, nb_w;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    na_w     = (op_w == OP_DIV) & a_w[W-1];
    nb_w     = (op_w == OP_DIV) & b_w[W-1];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          port_d  = win_idx;
          op_d    = op_w;
          a_d     = a_w;
          b_d     = b_w;
          state_d = S_DONE;
          case (op_w)
            OP_MULT, OP_MULTU, OP_MUL: begin
              if (MUL_NOW) begin
                result_d = product[W-1:0];
                if (op_w != OP_MUL) {hi_d, lo_d} = product;
              end else begin
                state_d = S_MUL_RUN;
                cnt_d   = CW'(MUL_LAT - 1);
              end
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV_RUN;
              cnt_d   = CW'(W);
              rem_d   = '0;
              quo_d   = na_w ? (~a_w + 1'b1) : a_w;
              dvs_d   = nb_w ? (~b_w + 1'b1) : b_w;
              q_neg_d = na_w ^ nb_w;
              r_neg_d = na_w;
              dz_d    = (b_w == '0);
            end
            OP_MTHI: begin
              hi_d     = a_w;
              result_d = a_w;
            end
            OP_MTLO: begin
              lo_d     = a_w;
              result_d = a_w;
            end
            OP_MFHI: result_d = hi_q;
            OP_MFLO: result_d = lo_q;
            default: result_d = '0;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = product[W-1:0];
          if (op_q != OP_MUL) {hi_d, lo_d} = product;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            lo_d     = lo_div;
            hi_d     = hi_div;
            result_d = lo_div;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_MUL_RUN) || (state_d == S_DIV_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      port_q   <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign done      = done_q;
  assign done_port = port_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: transaction-level reference model checked every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_mdu_issue_ctrl;

  localparam int NPORT   = 2;
  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NPORT-1:0]   valid = '0;
  logic [NPORT*4-1:0] op = '0;
  logic [NPORT*W-1:0] a = '0;
  logic [NPORT*W-1:0] b = '0;
  logic               flush = 1'b0;
  logic [NPORT-1:0]   ready;
  logic               done;
  logic [0:0]         done_port;
  logic [W-1:0]       result, hi, lo;
  logic               busy;

  mdu_issue_ctrl #(.NPORT(NPORT), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .ready(ready), .flush(flush), .done(done), .done_port(done_port),
    .result(result), .hi(hi), .lo(lo), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // reference model: one outstanding operation with its completion cycle
  int          cyc = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  bit          inf = 0;
  int          due = 0;
  int          inf_port = 0;
  logic [31:0] inf_res = '0, inf_hi = '0, inf_lo = '0;
  bit          inf_wr = 0;

  always @(negedge clk) begin
    bit          run, can, dn;
    logic [1:0]  exp_ready;
    int          p;
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [63:0] pr;
    int          sx, sy;
    if (!resetn) begin
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_result", result, 0);
      chk("rst_done_port", done_port, 0);
      hi_m = '0; lo_m = '0; inf = 0;
    end else begin
      run = inf && (due > cyc);
      can = !run && !flush;
      dn  = inf && (due == cyc);
      exp_ready = '0;
      p = -1;
      for (int i = NPORT - 1; i >= 0; i--) if (valid[i]) p = i;
      if (can && p >= 0) exp_ready[p] = 1'b1;
      chk("ready", ready, exp_ready);
      chk("busy", busy, run);
      chk("done", done, dn);
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
      if (dn) begin
        chk("done_port", done_port, inf_port);
        chk("result", result, inf_res);
      end
      if (inf && due <= cyc) inf = 0;
      if (run && flush) inf = 0;
      if (can && p >= 0) begin
        o = op[4*p +: 4];
        x = a[W*p +: W];
        y = b[W*p +: W];
        inf = 1; inf_port = p; inf_wr = 0; due = cyc + 1;
        case (o)
          4'd0, 4'd1, 4'd8: begin
            if (o == 4'd1) pr = {32'h0, x} * {32'h0, y};
            else           pr = longint'($signed(x)) * longint'($signed(y));
            due = cyc + MUL_LAT;
            inf_res = pr[31:0];
            if (o != 4'd8) begin inf_wr = 1; inf_hi = pr[63:32]; inf_lo = pr[31:0]; end
          end
          4'd2, 4'd3: begin
            due = cyc + W + 1;
            inf_wr = 1;
            if (y == 0) begin
              inf_lo = 32'hFFFF_FFFF; inf_hi = x;
            end else if (o == 4'd3) begin
              inf_lo = x / y; inf_hi = x % y;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
              inf_lo = 32'h8000_0000; inf_hi = 0;
            end else begin
              sx = $signed(x); sy = $signed(y);
              inf_lo = 32'(sx / sy); inf_hi = 32'(sx % sy);
            end
            inf_res = inf_lo;
          end
          4'd4: begin hi_m = x; inf_res = x; end
          4'd5: begin lo_m = x; inf_res = x; end
          4'd6: inf_res = hi_m;
          4'd7: inf_res = lo_m;
          default: inf_res = 0;
        endcase
      end
      if (inf && inf_wr && due == cyc + 1) begin
        hi_m = inf_hi; lo_m = inf_lo;
      end
    end
    cyc++;
  end

  // driver tasks
  task automatic at_drive();
    @(posedge clk); #1;
  endtask

  task automatic at_sample();
    @(negedge clk); #1;
  endtask

  task automatic set_port(input int p, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op[4*p +: 4] = o;
    a[W*p +: W]  = x;
    b[W*p +: W]  = y;
  endtask

  task automatic run_div(input string name, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] elo, input logic [31:0] ehi);
    at_drive(); valid = 2'b01; flush = 0; set_port(0, o, x, y);
    at_sample();
    at_drive(); valid = 2'b00; set_port(0, 4'hF, $urandom, $urandom);
    at_sample();
    for (int i = 2; i <= 32; i++) begin at_drive(); at_sample(); end
    chk({name, "_early"}, done, 0);
    at_drive(); at_sample();
    chk({name, "_done"}, done, 1);
    chk({name, "_lo"}, lo, elo);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_result"}, result, elo);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) begin at_drive(); end
    resetn = 1;

    // port0 MULT wins over port1 MFLO; MFLO accepted in the DONE cycle
    at_drive(); valid = 2'b11; set_port(0, 4'd0, 32'hFFFF_FFFE, 32'd3); set_port(1, 4'd7, 0, 0);
    at_sample(); chk("p037_ready", ready, 2'b01);
    at_drive(); valid = 2'b10; at_sample(); chk("p037_busy", busy, 1);
    at_drive(); at_sample();
    at_drive(); at_sample();
    chk("p037_done", done, 1);
    chk("p037_port", done_port, 0);
    chk("p037_hi", hi, 32'hFFFF_FFFF);
    chk("p037_lo", lo, 32'hFFFF_FFFA);
    chk("p037_ready1", ready, 2'b10);
    at_drive(); valid = 2'b00; at_sample();
    chk("p037_mflo_done", done, 1);
    chk("p037_mflo_port", done_port, 1);
    chk("p037_mflo_res", result, 32'hFFFF_FFFA);

    // MTHI then MFHI back-to-back, then MUL leaves hi/lo alone
    at_drive(); valid = 2'b01; set_port(0, 4'd4, 32'h1234, 0); at_sample();
    at_drive(); set_port(0, 4'd6, 0, 0); at_sample();
    chk("p041_mthi_res", result, 32'h1234);
    at_drive(); valid = 2'b00; at_sample();
    chk("p041_mfhi_done", done, 1);
    chk("p041_mfhi_res", result, 32'h1234);
    at_drive(); valid = 2'b01; set_port(0, 4'd8, 32'd6, 32'd7); at_sample();
    at_drive(); valid = 2'b00; at_sample();
    at_drive(); at_sample();
    at_drive(); at_sample();
    chk("p041_mul_done", done, 1);
    chk("p041_mul_res", result, 32'd42);
    chk("p041_mul_hi", hi, 32'h1234);
    chk("p041_mul_lo", lo, 32'hFFFF_FFFA);

    run_div("divu_7_2", 4'd3, 32'd7, 32'd2, 32'd3, 32'd1);
    run_div("div_minneg", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    run_div("div_neg7_2", 4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_5_0", 4'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // flush 10 cycles into a divide
    at_drive(); valid = 2'b01; set_port(0, 4'd2, 32'd100, 32'd3); at_sample();
    at_drive(); valid = 2'b00; at_sample();
    for (int i = 2; i <= 9; i++) begin at_drive(); at_sample(); end
    at_drive(); flush = 1; at_sample();
    at_drive(); flush = 0; valid = 2'b11; set_port(0, 4'd9, 0, 0); set_port(1, 4'd9, 0, 0);
    at_sample();
    chk("flush_ready", ready, 2'b01);
    chk("flush_busy", busy, 0);
    chk("flush_nodone", done, 0);
    chk("flush_hi", hi, 32'd5);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    at_drive(); valid = 2'b00; at_sample();
    chk("nop_done", done, 1);
    chk("nop_res", result, 0);

    // reset in the middle of a divide
    at_drive(); valid = 2'b01; set_port(0, 4'd3, 32'd1000, 32'd7); at_sample();
    at_drive(); valid = 2'b00; at_sample();
    for (int i = 0; i < 4; i++) begin at_drive(); at_sample(); end
    at_drive(); resetn = 0; at_sample();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    at_drive(); at_sample();
    at_drive(); resetn = 1; at_sample();
    for (int i = 0; i < 40; i++) begin
      at_drive(); at_sample();
      chk("mid_rst_nodone", done, 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      at_drive();
      resetn = ($urandom_range(0, 499) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      valid  = 2'($urandom_range(0, 3));
      for (int p = 0; p < NPORT; p++)
        set_port(p, ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8)),
                 pick_val(), pick_val());
    end
    at_drive(); resetn = 1; valid = 0; flush = 0;
    repeat (40) at_drive();
    at_sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
